// File: rtl/hack_pkg.sv
// Shared constants and loader state encoding for the Hack ROM loader.
// Optional build macro: HACK_LOADER_CHECKSUM_EN adds the CHK state, which
// expects a trailing XOR check byte after each frame.
package hack_pkg;

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam int unsigned WORD_W    = 16;

  typedef enum logic [2:0] {
    S_RUN,
    S_CNT_HI,
    S_CNT_LO,
    S_DAT_HI,
    S_DAT_LO,
`ifdef HACK_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_ERR
  } loaderState_t;

endpackage

// File: rtl/hack_rom_dp.sv
// Program ROM: 2**ADDR_W x 16.
// It has a synchronous write port and an asynchronous read port, so it maps to
// distributed RAM. A fetch from the address being written in the same cycle
// returns the old word.
module hack_rom_dp
  import hack_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   wrAddr,
  input  logic [WORD_W-1:0]   wrData,
  input  logic [ADDR_W-1:0]   rdAddr,
  output logic [WORD_W-1:0]   rdData
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  // Write port: one word per enabled clock.
  always_ff @(posedge clk) begin
    if (we) mem[wrAddr] <= wrData;
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/hack_rom_loader.sv
// Instruction store and byte-stream program loader for the Hack cpu.
// Frame format: A5, N_hi, N_lo, then N words sent hi byte first.
// Optional build macro: HACK_LOADER_CHECKSUM_EN appends an XOR check byte to
// each frame, covering N_hi, N_lo and all data bytes.
module hack_rom_loader
  import hack_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic [14:0]       pc,
  output logic [15:0]       instruction,
  output logic              cpu_reset,
  output logic              loading,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned     TO_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [16:0]     MAX_WORDS = 17'(2**ADDR_W);

  loaderState_t      state;
  logic [15:0]       wordCnt;
  logic [7:0]        hiByte;
  logic [TO_W-1:0]   idleCnt;
  logic              inLoad;
  logic              timeoutHit;
  logic [15:0]       cntFull;
  logic [ADDR_W:0]   wordsNext;
  logic              romWe;
  logic [15:0]       romRdData;
  logic              pcOutOfRange;
`ifdef HACK_LOADER_CHECKSUM_EN
  logic [7:0]        chkSum;
`endif

  // Decode load activity, timeout expiry and the word-count / write strobes.
  always_comb begin
    inLoad     = (state != S_RUN) && (state != S_ERR);
    timeoutHit = inLoad && !rx_valid && (idleCnt == TO_LAST);
    cntFull    = {wordCnt[15:8], rx_data};
    wordsNext  = words_loaded + 1'b1;
    romWe      = (state == S_DAT_LO) && rx_valid;
  end

  // Idle-clock counter: runs only mid-load, cleared by any received byte.
  always_ff @(posedge clk) begin
    if (reset || rx_valid || !inLoad) idleCnt <= '0;
    else                              idleCnt <= idleCnt + 1'b1;
  end

  // Loader FSM with registered cpu_reset / loading / load_err / words_loaded.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_RUN;
      cpu_reset    <= 1'b1;
      loading      <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
      wordCnt      <= '0;
      hiByte       <= '0;
`ifdef HACK_LOADER_CHECKSUM_EN
      chkSum       <= '0;
`endif
    end else if (timeoutHit) begin
      state     <= S_ERR;
      loading   <= 1'b0;
      load_err  <= 1'b1;
      cpu_reset <= 1'b1;
    end else begin
      unique case (state)
        // RUN and ERR share the sync-byte restart; only RUN releases the cpu.
        S_RUN, S_ERR: begin
          if (state == S_RUN) cpu_reset <= 1'b0;
          if (rx_valid && rx_data == SYNC_BYTE) begin
            state        <= S_CNT_HI;
            loading      <= 1'b1;
            load_err     <= 1'b0;
            cpu_reset    <= 1'b1;
            words_loaded <= '0;
`ifdef HACK_LOADER_CHECKSUM_EN
            chkSum       <= '0;
`endif
          end
        end
        S_CNT_HI: if (rx_valid) begin
          wordCnt[15:8] <= rx_data;
          state         <= S_CNT_LO;
`ifdef HACK_LOADER_CHECKSUM_EN
          chkSum        <= chkSum ^ rx_data;
`endif
        end
        S_CNT_LO: if (rx_valid) begin
          wordCnt[7:0] <= rx_data;
`ifdef HACK_LOADER_CHECKSUM_EN
          chkSum       <= chkSum ^ rx_data;
`endif
          if ({1'b0, cntFull} > MAX_WORDS) begin
            state    <= S_ERR;
            loading  <= 1'b0;
            load_err <= 1'b1;
          end else if (cntFull == 16'h0000) begin
`ifdef HACK_LOADER_CHECKSUM_EN
            state   <= S_CHK;
`else
            state   <= S_RUN;
            loading <= 1'b0;
`endif
          end else begin
            state <= S_DAT_HI;
          end
        end
        S_DAT_HI: if (rx_valid) begin
          hiByte <= rx_data;
          state  <= S_DAT_LO;
`ifdef HACK_LOADER_CHECKSUM_EN
          chkSum <= chkSum ^ rx_data;
`endif
        end
        // The write address is words_loaded itself, so no separate pointer.
        S_DAT_LO: if (rx_valid) begin
          words_loaded <= wordsNext;
`ifdef HACK_LOADER_CHECKSUM_EN
          chkSum       <= chkSum ^ rx_data;
`endif
          if (17'(wordsNext) == {1'b0, wordCnt}) begin
`ifdef HACK_LOADER_CHECKSUM_EN
            state   <= S_CHK;
`else
            state   <= S_RUN;
            loading <= 1'b0;
`endif
          end else begin
            state <= S_DAT_HI;
          end
        end
`ifdef HACK_LOADER_CHECKSUM_EN
        S_CHK: if (rx_valid) begin
          loading <= 1'b0;
          if (rx_data == chkSum) begin
            state <= S_RUN;
          end else begin
            state    <= S_ERR;
            load_err <= 1'b1;
          end
        end
`endif
        default: state <= S_RUN;
      endcase
    end
  end

  hack_rom_dp #(
    .ADDR_W (ADDR_W)
  ) uRom (
    .clk    (clk),
    .we     (romWe),
    .wrAddr (words_loaded[ADDR_W-1:0]),
    .wrData ({hiByte, rx_data}),
    .rdAddr (pc[ADDR_W-1:0]),
    .rdData (romRdData)
  );

  if (ADDR_W < 15) begin : gPcHi
    assign pcOutOfRange = |pc[14:ADDR_W];
  end else begin : gPcFull
    assign pcOutOfRange = 1'b0;
  end

  assign instruction = pcOutOfRange ? '0 : romRdData;

endmodule

// File: tb/tb_hack_rom_loader.sv
// Directed testbench for hack_rom_loader (ADDR_W=12, short timeout).
// Build with HACK_LOADER_CHECKSUM_EN defined to exercise the check-byte variant.
module tb_hack_rom_loader;

  localparam int unsigned TO = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [14:0] pc;
  logic [15:0] instruction;
  logic        cpu_reset;
  logic        loading;
  logic        load_err;
  logic [12:0] words_loaded;

  int passCnt  = 0;
  int totalCnt = 0;

  hack_rom_loader #(
    .ADDR_W      (12),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .pc           (pc),
    .instruction  (instruction),
    .cpu_reset    (cpu_reset),
    .loading      (loading),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  // Present one byte for exactly one rising edge; returns 1 time unit after it.
  task automatic sendByte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [14:0] a, output logic [15:0] v);
    pc = a;
    #1;
    v = instruction;
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; pc = '0;
    repeat (2) @(posedge clk);
    #1;
    totalCnt++; if (cpu_reset !== 1'b1) $display("FAIL rst_cpu_reset: got %b want 1", cpu_reset); else passCnt++;
    totalCnt++; if (loading !== 1'b0) $display("FAIL rst_loading: got %b want 0", loading); else passCnt++;
    totalCnt++; if (load_err !== 1'b0) $display("FAIL rst_load_err: got %b want 0", load_err); else passCnt++;
    totalCnt++; if (words_loaded !== 13'd0) $display("FAIL rst_words: got %0d want 0", words_loaded); else passCnt++;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    totalCnt++; if (cpu_reset !== 1'b0) $display("FAIL rst_release: got %b want 0", cpu_reset); else passCnt++;
  endtask

  task automatic test_load();
    logic [7:0]  q[$];
    logic [15:0] v;
    sendByte(8'hA5);
    totalCnt++; if (loading !== 1'b1) $display("FAIL load_start_loading: got %b want 1", loading); else passCnt++;
    totalCnt++; if (cpu_reset !== 1'b1) $display("FAIL load_start_cpu_reset: got %b want 1", cpu_reset); else passCnt++;
    q = '{8'h00, 8'h02, 8'h30, 8'h39, 8'hEC, 8'h10};
`ifdef HACK_LOADER_CHECKSUM_EN
    q.push_back(8'hF7);
`endif
    foreach (q[i]) sendByte(q[i]);
    totalCnt++; if (loading !== 1'b0) $display("FAIL load_done_loading: got %b want 0", loading); else passCnt++;
    totalCnt++; if (load_err !== 1'b0) $display("FAIL load_done_err: got %b want 0", load_err); else passCnt++;
    totalCnt++; if (words_loaded !== 13'd2) $display("FAIL load_words: got %0d want 2", words_loaded); else passCnt++;
    totalCnt++; if (cpu_reset !== 1'b1) $display("FAIL load_cpu_reset_held: got %b want 1", cpu_reset); else passCnt++;
    idle(1);
    totalCnt++; if (cpu_reset !== 1'b0) $display("FAIL load_cpu_release: got %b want 0", cpu_reset); else passCnt++;
    peek(15'd0, v);
    totalCnt++; if (v !== 16'h3039) $display("FAIL load_rom0: got %h want 3039", v); else passCnt++;
    peek(15'd1, v);
    totalCnt++; if (v !== 16'hEC10) $display("FAIL load_rom1: got %h want ec10", v); else passCnt++;
  endtask

  task automatic test_zero();
    logic [15:0] v;
    sendByte(8'hA5); sendByte(8'h00); sendByte(8'h00);
`ifdef HACK_LOADER_CHECKSUM_EN
    sendByte(8'h00);
`endif
    totalCnt++; if (loading !== 1'b0) $display("FAIL zero_loading: got %b want 0", loading); else passCnt++;
    totalCnt++; if (load_err !== 1'b0) $display("FAIL zero_err: got %b want 0", load_err); else passCnt++;
    totalCnt++; if (words_loaded !== 13'd0) $display("FAIL zero_words: got %0d want 0", words_loaded); else passCnt++;
    idle(1);
    totalCnt++; if (cpu_reset !== 1'b0) $display("FAIL zero_cpu_release: got %b want 0", cpu_reset); else passCnt++;
    peek(15'd0, v);
    totalCnt++; if (v !== 16'h3039) $display("FAIL zero_rom0: got %h want 3039", v); else passCnt++;
    peek(15'd1, v);
    totalCnt++; if (v !== 16'hEC10) $display("FAIL zero_rom1: got %h want ec10", v); else passCnt++;
  endtask

  // N == 2**ADDR_W is the largest legal image and must not be rejected.
  task automatic test_full();
    logic [15:0] w;
    logic [15:0] v;
    logic [7:0]  chk;
    sendByte(8'hA5); sendByte(8'h10); sendByte(8'h00);
    chk = 8'h10 ^ 8'h00;
    for (int i = 0; i < 4096; i++) begin
      w = 16'hC000 | 16'(i);
      sendByte(w[15:8]);
      sendByte(w[7:0]);
      chk = chk ^ w[15:8] ^ w[7:0];
    end
`ifdef HACK_LOADER_CHECKSUM_EN
    sendByte(chk);
`endif
    totalCnt++; if (words_loaded !== 13'h1000) $display("FAIL full_words: got %h want 1000", words_loaded); else passCnt++;
    totalCnt++; if (load_err !== 1'b0) $display("FAIL full_err: got %b want 0", load_err); else passCnt++;
    totalCnt++; if (loading !== 1'b0) $display("FAIL full_loading: got %b want 0", loading); else passCnt++;
    peek(15'd0, v);
    totalCnt++; if (v !== 16'hC000) $display("FAIL full_rom0: got %h want c000", v); else passCnt++;
    peek(15'd2048, v);
    totalCnt++; if (v !== 16'hC800) $display("FAIL full_rom2048: got %h want c800", v); else passCnt++;
    peek(15'd4095, v);
    totalCnt++; if (v !== 16'hCFFF) $display("FAIL full_rom4095: got %h want cfff", v); else passCnt++;
  endtask

  task automatic test_overflow();
    logic [15:0] v;
    sendByte(8'hA5); sendByte(8'h10); sendByte(8'h01);
    totalCnt++; if (load_err !== 1'b1) $display("FAIL ovf_err: got %b want 1", load_err); else passCnt++;
    totalCnt++; if (loading !== 1'b0) $display("FAIL ovf_loading: got %b want 0", loading); else passCnt++;
    sendByte(8'h33);
    idle(2);
    totalCnt++; if (load_err !== 1'b1) $display("FAIL ovf_err_sticky: got %b want 1", load_err); else passCnt++;
    totalCnt++; if (cpu_reset !== 1'b1) $display("FAIL ovf_cpu_reset: got %b want 1", cpu_reset); else passCnt++;
    sendByte(8'hA5);
    totalCnt++; if (load_err !== 1'b0) $display("FAIL ovf_restart_err: got %b want 0", load_err); else passCnt++;
    totalCnt++; if (loading !== 1'b1) $display("FAIL ovf_restart_loading: got %b want 1", loading); else passCnt++;
    sendByte(8'h00); sendByte(8'h01); sendByte(8'hAB); sendByte(8'hCD);
`ifdef HACK_LOADER_CHECKSUM_EN
    sendByte(8'h67);
`endif
    totalCnt++; if (words_loaded !== 13'd1) $display("FAIL ovf_words: got %0d want 1", words_loaded); else passCnt++;
    totalCnt++; if (load_err !== 1'b0) $display("FAIL ovf_done_err: got %b want 0", load_err); else passCnt++;
    peek(15'd0, v);
    totalCnt++; if (v !== 16'hABCD) $display("FAIL ovf_rom0: got %h want abcd", v); else passCnt++;
    peek(15'd1, v);
    totalCnt++; if (v !== 16'hC001) $display("FAIL ovf_rom1: got %h want c001", v); else passCnt++;
  endtask

  task automatic test_timeout();
    logic [15:0] v;
    sendByte(8'hA5); sendByte(8'h00); sendByte(8'h01); sendByte(8'h12);
    idle(TO - 1);
    totalCnt++; if (loading !== 1'b1) $display("FAIL to_before_loading: got %b want 1", loading); else passCnt++;
    totalCnt++; if (load_err !== 1'b0) $display("FAIL to_before_err: got %b want 0", load_err); else passCnt++;
    idle(1);
    totalCnt++; if (load_err !== 1'b1) $display("FAIL to_err: got %b want 1", load_err); else passCnt++;
    totalCnt++; if (loading !== 1'b0) $display("FAIL to_loading: got %b want 0", loading); else passCnt++;
    totalCnt++; if (cpu_reset !== 1'b1) $display("FAIL to_cpu_reset: got %b want 1", cpu_reset); else passCnt++;
    // Restart with gaps one clock short of the limit: must not time out.
    sendByte(8'hA5); idle(TO - 1);
    totalCnt++; if (loading !== 1'b1) $display("FAIL to_restart_loading: got %b want 1", loading); else passCnt++;
    sendByte(8'h00); idle(TO - 1);
    sendByte(8'h01); idle(TO - 1);
    sendByte(8'h12); idle(TO - 1);
    sendByte(8'h34);
`ifdef HACK_LOADER_CHECKSUM_EN
    idle(TO - 1);
    sendByte(8'h27);
`endif
    totalCnt++; if (load_err !== 1'b0) $display("FAIL to_gap_err: got %b want 0", load_err); else passCnt++;
    totalCnt++; if (loading !== 1'b0) $display("FAIL to_gap_loading: got %b want 0", loading); else passCnt++;
    peek(15'd0, v);
    totalCnt++; if (v !== 16'h1234) $display("FAIL to_rom0: got %h want 1234", v); else passCnt++;
  endtask

  task automatic test_reset_midload();
    logic [15:0] v;
    sendByte(8'hA5); sendByte(8'h00); sendByte(8'h02); sendByte(8'h77); sendByte(8'h88);
    totalCnt++; if (words_loaded !== 13'd1) $display("FAIL mid_words: got %0d want 1", words_loaded); else passCnt++;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    totalCnt++; if (loading !== 1'b0) $display("FAIL mid_loading: got %b want 0", loading); else passCnt++;
    totalCnt++; if (cpu_reset !== 1'b1) $display("FAIL mid_cpu_reset: got %b want 1", cpu_reset); else passCnt++;
    totalCnt++; if (words_loaded !== 13'd0) $display("FAIL mid_words_rst: got %0d want 0", words_loaded); else passCnt++;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    totalCnt++; if (cpu_reset !== 1'b0) $display("FAIL mid_release: got %b want 0", cpu_reset); else passCnt++;
    peek(15'd0, v);
    totalCnt++; if (v !== 16'h7788) $display("FAIL mid_rom0: got %h want 7788", v); else passCnt++;
  endtask

  task automatic test_checksum();
    logic [7:0]  q[$];
    logic [15:0] v;
    q = '{8'hA5, 8'h00, 8'h02, 8'h30, 8'h39, 8'hEC, 8'h10};
    foreach (q[i]) sendByte(q[i]);
`ifdef HACK_LOADER_CHECKSUM_EN
    sendByte(8'h00);
    totalCnt++; if (load_err !== 1'b1) $display("FAIL chk_err: got %b want 1", load_err); else passCnt++;
    totalCnt++; if (loading !== 1'b0) $display("FAIL chk_loading: got %b want 0", loading); else passCnt++;
    idle(2);
    totalCnt++; if (cpu_reset !== 1'b1) $display("FAIL chk_cpu_reset: got %b want 1", cpu_reset); else passCnt++;
`else
    sendByte(8'hF7);
    totalCnt++; if (loading !== 1'b0) $display("FAIL trail_loading: got %b want 0", loading); else passCnt++;
    totalCnt++; if (load_err !== 1'b0) $display("FAIL trail_err: got %b want 0", load_err); else passCnt++;
    totalCnt++; if (cpu_reset !== 1'b0) $display("FAIL trail_cpu_reset: got %b want 0", cpu_reset); else passCnt++;
`endif
    peek(15'd0, v);
    totalCnt++; if (v !== 16'h3039) $display("FAIL chk_rom0: got %h want 3039", v); else passCnt++;
    peek(15'd1, v);
    totalCnt++; if (v !== 16'hEC10) $display("FAIL chk_rom1: got %h want ec10", v); else passCnt++;
  endtask

  task automatic test_pc_range();
    logic [15:0] v;
    peek(15'h1000, v);
    totalCnt++; if (v !== 16'h0000) $display("FAIL pc_1000: got %h want 0000", v); else passCnt++;
    peek(15'h7FFF, v);
    totalCnt++; if (v !== 16'h0000) $display("FAIL pc_7fff: got %h want 0000", v); else passCnt++;
    peek(15'h4FFF, v);
    totalCnt++; if (v !== 16'h0000) $display("FAIL pc_4fff: got %h want 0000", v); else passCnt++;
    peek(15'h0FFF, v);
    totalCnt++; if (v !== 16'hCFFF) $display("FAIL pc_0fff: got %h want cfff", v); else passCnt++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_zero();
    test_full();
    test_overflow();
    test_timeout();
    test_reset_midload();
    test_checksum();
    test_pc_range();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
